// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry holding
// buffer for decode stalls, redirect handling with a drain of in-flight requests.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] IR,
   output logic [31:0] PC_1,
   output logic        ir_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_e;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc_1;
   } fetch_word_t;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   fetch_word_t buf_q, buf_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_1_q, pc_1_d;
   logic        ir_valid_q, ir_valid_d;

   logic        xfer;
   logic [31:0] pc_inc;

   // Request and address decode from registers only; DRAIN keeps the old address
   // on the bus while pc already points at the redirect target.
   assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
   assign xfer      = imem_req && imem_ready;
   assign pc_inc    = pc_q + 32'd1;

   assign IR       = ir_q;
   assign PC_1     = pc_1_q;
   assign ir_valid = ir_valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      buf_d        = buf_q;
      ir_d         = ir_q;
      pc_1_d       = pc_1_q;
      ir_valid_d   = ir_valid_q;

      if (redirect) begin
         pc_d       = redirect_pc;
         ir_d       = 32'h0;
         ir_valid_d = 1'b0;
         buf_d      = '0;
         if (imem_req && !imem_ready) begin
            state_d = DRAIN;
            // A second redirect in DRAIN must not move the outstanding address.
            drain_addr_d = imem_addr;
         end else begin
            state_d = FETCH;
         end
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (xfer) begin
                  pc_d = pc_inc;
                  if (!stall) begin
                     ir_d       = imem_rdata;
                     pc_1_d     = pc_inc;
                     ir_valid_d = 1'b1;
                  end else begin
                     buf_d   = '{ir: imem_rdata, pc_1: pc_inc};
                     state_d = FULL;
                  end
               end else if (!stall) begin
                  ir_d       = 32'h0;
                  ir_valid_d = 1'b0;
               end
            end
            FULL: begin
               if (!stall) begin
                  ir_d       = buf_q.ir;
                  pc_1_d     = buf_q.pc_1;
                  ir_valid_d = 1'b1;
                  buf_d      = '0;
                  state_d    = FETCH;
               end
            end
            DRAIN: begin
               if (!stall) begin
                  ir_d       = 32'h0;
                  ir_valid_d = 1'b0;
               end
               if (imem_ready) state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         buf_q        <= '0;
         ir_q         <= 32'h0;
         pc_1_q       <= 32'h0;
         ir_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         buf_q        <= buf_d;
         ir_q         <= ir_d;
         pc_1_q       <= pc_1_d;
         ir_valid_q   <= ir_valid_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: table of per-cycle vectors plus
// a hand-written asynchronous reset during a memory wait.
module tb_instruction_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] IR;
   logic [31:0] PC_1;
   logic        ir_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   instruction_fetch_stage #(.RESET_PC(32'h10)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .IR(IR), .PC_1(PC_1), .ir_valid(ir_valid)
   );

   typedef struct {
      logic        stall;
      logic        redirect;
      logic        ready;
      logic [31:0] rpc;
      logic        req;   // expected during the cycle
      logic [31:0] addr;
      logic [31:0] ir;    // expected after the edge
      logic [31:0] pc1;
      logic        v;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic st, input logic rd, input logic rdy,
                               input logic [31:0] rpc, input logic req,
                               input logic [31:0] addr, input logic [31:0] ir,
                               input logic [31:0] pc1, input logic v);
      vec_t r;
      r.stall = st; r.redirect = rd; r.ready = rdy; r.rpc = rpc;
      r.req = req; r.addr = addr; r.ir = ir; r.pc1 = pc1; r.v = v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // st rd rdy rpc           | req addr          | IR                 PC_1          v
      vecs[0]  = mk(0,0,1,32'h0,        0,32'h10,       32'h0,             32'h0,        0);
      vecs[1]  = mk(0,0,1,32'h0,        1,32'h10,       mem(32'h10),       32'h11,       1);
      vecs[2]  = mk(0,0,1,32'h0,        1,32'h11,       mem(32'h11),       32'h12,       1);
      vecs[3]  = mk(0,1,1,32'h5,        1,32'h12,       32'h0,             32'h12,       0);
      vecs[4]  = mk(0,0,0,32'h0,        1,32'h5,        32'h0,             32'h12,       0);
      vecs[5]  = mk(0,0,0,32'h0,        1,32'h5,        32'h0,             32'h12,       0);
      vecs[6]  = mk(0,0,1,32'h0,        1,32'h5,        mem(32'h5),        32'h6,        1);
      vecs[7]  = mk(0,0,1,32'h0,        1,32'h6,        mem(32'h6),        32'h7,        1);
      vecs[8]  = mk(0,0,1,32'h0,        1,32'h7,        mem(32'h7),        32'h8,        1);
      vecs[9]  = mk(1,0,1,32'h0,        1,32'h8,        mem(32'h7),        32'h8,        1);
      vecs[10] = mk(1,0,1,32'h0,        0,32'h9,        mem(32'h7),        32'h8,        1);
      vecs[11] = mk(1,0,1,32'h0,        0,32'h9,        mem(32'h7),        32'h8,        1);
      vecs[12] = mk(0,0,1,32'h0,        0,32'h9,        mem(32'h8),        32'h9,        1);
      vecs[13] = mk(0,0,1,32'h0,        1,32'h9,        mem(32'h9),        32'hA,        1);
      vecs[14] = mk(0,1,1,32'h40,       1,32'hA,        32'h0,             32'hA,        0);
      vecs[15] = mk(0,0,1,32'h0,        1,32'h40,       mem(32'h40),       32'h41,       1);
      vecs[16] = mk(0,1,1,32'h3,        1,32'h41,       32'h0,             32'h41,       0);
      vecs[17] = mk(0,0,0,32'h0,        1,32'h3,        32'h0,             32'h41,       0);
      vecs[18] = mk(0,1,0,32'h80,       1,32'h3,        32'h0,             32'h41,       0);
      vecs[19] = mk(0,0,1,32'h0,        1,32'h3,        32'h0,             32'h41,       0);
      vecs[20] = mk(0,0,1,32'h0,        1,32'h80,       mem(32'h80),       32'h81,       1);
      vecs[21] = mk(0,1,1,32'hFFFF_FFFF,1,32'h81,       32'h0,             32'h81,       0);
      vecs[22] = mk(0,0,1,32'h0,        1,32'hFFFF_FFFF,mem(32'hFFFF_FFFF),32'h0,        1);
      vecs[23] = mk(0,0,1,32'h0,        1,32'h0,        mem(32'h0),        32'h1,        1);
      vecs[24] = mk(0,1,0,32'h20,       1,32'h1,        32'h0,             32'h1,        0);
      vecs[25] = mk(0,1,0,32'h30,       1,32'h1,        32'h0,             32'h1,        0);
      vecs[26] = mk(0,0,1,32'h0,        1,32'h1,        32'h0,             32'h1,        0);
      vecs[27] = mk(0,0,1,32'h0,        1,32'h30,       mem(32'h30),       32'h31,       1);

      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_req",   {31'h0, imem_req}, 32'h0);
      chk("reset_ir",    IR, 32'h0);
      chk("reset_valid", {31'h0, ir_valid}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk);
         stall = vecs[i].stall; redirect = vecs[i].redirect;
         imem_ready = vecs[i].ready; redirect_pc = vecs[i].rpc;
         #1;
         chk($sformatf("v%0d_req", i),  {31'h0, imem_req}, {31'h0, vecs[i].req});
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
         @(posedge clk); #1;
         chk($sformatf("v%0d_ir", i),    IR, vecs[i].ir);
         chk($sformatf("v%0d_pc1", i),   PC_1, vecs[i].pc1);
         chk($sformatf("v%0d_valid", i), {31'h0, ir_valid}, {31'h0, vecs[i].v});
      end

      // Reset in the middle of a memory wait at address 0x31
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
      #1;
      chk("midrst_pre_req",  {31'h0, imem_req}, 32'h1);
      chk("midrst_pre_addr", imem_addr, 32'h31);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_req",   {31'h0, imem_req}, 32'h0);
      chk("midrst_addr",  imem_addr, 32'h10);
      chk("midrst_ir",    IR, 32'h0);
      chk("midrst_pc1",   PC_1, 32'h0);
      chk("midrst_valid", {31'h0, ir_valid}, 32'h0);
      @(negedge clk);
      imem_ready = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_idle_req", {31'h0, imem_req}, 32'h1);
      @(posedge clk); #1;
      chk("post_ir",  IR, mem(32'h10));
      chk("post_pc1", PC_1, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
